// File: rtl/alu_rr_scheduler.sv
// Two-requester round-robin front end for a shared ALU_TOP.
// Grants one operation at a time, holds the ALU operands while the ALU's
// registered result settles, and returns the selected result group on a
// shared response bus tagged with the owning requester.
`timescale 1ns/1ps
module alu_rr_scheduler #(
    parameter int DATA_WIDTH  = 16,
    parameter int ALU_LATENCY = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0_VALID,
    output logic                  REQ0_READY,
    input  logic [DATA_WIDTH-1:0] REQ0_A,
    input  logic [DATA_WIDTH-1:0] REQ0_B,
    input  logic [3:0]            REQ0_FUN,
    input  logic                  REQ1_VALID,
    output logic                  REQ1_READY,
    input  logic [DATA_WIDTH-1:0] REQ1_A,
    input  logic [DATA_WIDTH-1:0] REQ1_B,
    input  logic [3:0]            REQ1_FUN,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_ID,
    output logic [DATA_WIDTH-1:0] RSP_DATA,
    output logic                  RSP_CARRY,
    output logic [3:0]            RSP_FLAGS,
    output logic                  RSP_ERR,
    output logic                  BUSY,
    output logic [DATA_WIDTH-1:0] ALU_A,
    output logic [DATA_WIDTH-1:0] ALU_B,
    output logic [3:0]            ALU_FUN,
    input  logic [DATA_WIDTH-1:0] ALU_ARITH_OUT,
    input  logic [DATA_WIDTH-1:0] ALU_LOGIC_OUT,
    input  logic [DATA_WIDTH-1:0] ALU_CMP_OUT,
    input  logic [DATA_WIDTH-1:0] ALU_SHIFT_OUT,
    input  logic                  ALU_CARRY_OUT,
    input  logic                  ALU_ARITH_FLAG,
    input  logic                  ALU_LOGIC_FLAG,
    input  logic                  ALU_CMP_FLAG,
    input  logic                  ALU_SHIFT_FLAG
);

    localparam logic [2:0] LAT_C     = 3'(ALU_LATENCY);
    localparam logic [3:0] FUN_DIV_C = 4'b0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Flag pattern the ALU must raise for a given function class.
    function automatic logic [3:0] class_flags(input logic [1:0] cls);
        logic [3:0] f;
        case (cls)
            2'b00:   f = 4'b1000;
            2'b01:   f = 4'b0100;
            2'b10:   f = 4'b0010;
            2'b11:   f = 4'b0001;
            default: f = 4'b0000;
        endcase
        return f;
    endfunction

    state_t                  state_r, state_s;
    logic                    prio_r;
    logic                    id_r;
    logic [2:0]              cnt_r;
    logic [1:0]              cls_r;
    logic                    busy_r;

    logic                    gnt_vld_s;
    logic                    gnt_id_s;
    logic [DATA_WIDTH-1:0]   sel_a_s;
    logic [DATA_WIDTH-1:0]   sel_b_s;
    logic [3:0]              sel_fun_s;
    logic                    div0_s;

    logic [DATA_WIDTH-1:0]   res_data_s;
    logic                    res_carry_s;
    logic [3:0]              res_flags_s;
    logic                    res_err_s;

    logic [DATA_WIDTH-1:0]   alu_a_r;
    logic [DATA_WIDTH-1:0]   alu_b_r;
    logic [3:0]              alu_fun_r;
    logic                    rsp_valid_r;
    logic                    rsp_id_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic                    rsp_carry_r;
    logic [3:0]              rsp_flags_r;
    logic                    rsp_err_r;

    // Arbitration: only in IDLE; PRIO breaks ties when both requesters are valid.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            if (REQ0_VALID && REQ1_VALID) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = prio_r;
            end else if (REQ0_VALID) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = 1'b0;
            end else if (REQ1_VALID) begin
                gnt_vld_s = 1'b1;
                gnt_id_s  = 1'b1;
            end else begin
                gnt_vld_s = 1'b0;
                gnt_id_s  = 1'b0;
            end
        end else begin
            gnt_vld_s = 1'b0;
            gnt_id_s  = 1'b0;
        end
    end

    assign REQ0_READY = gnt_vld_s & ~gnt_id_s;
    assign REQ1_READY = gnt_vld_s &  gnt_id_s;

    // Operand mux for the granted requester plus divide-by-zero detection.
    always_comb begin
        sel_a_s   = REQ0_A;
        sel_b_s   = REQ0_B;
        sel_fun_s = REQ0_FUN;
        if (gnt_id_s) begin
            sel_a_s   = REQ1_A;
            sel_b_s   = REQ1_B;
            sel_fun_s = REQ1_FUN;
        end else begin
            sel_a_s   = REQ0_A;
            sel_b_s   = REQ0_B;
            sel_fun_s = REQ0_FUN;
        end
        div0_s = (sel_fun_s == FUN_DIV_C) && (sel_b_s == {DATA_WIDTH{1'b0}});
    end

    // Pick the ALU output group for the latched class and judge the flags.
    always_comb begin
        res_data_s  = ALU_ARITH_OUT;
        res_carry_s = 1'b0;
        case (cls_r)
            2'b00: begin
                res_data_s  = ALU_ARITH_OUT;
                res_carry_s = ALU_CARRY_OUT;
            end
            2'b01:   res_data_s = ALU_LOGIC_OUT;
            2'b10:   res_data_s = ALU_CMP_OUT;
            2'b11:   res_data_s = ALU_SHIFT_OUT;
            default: res_data_s = ALU_ARITH_OUT;
        endcase
        res_flags_s = {ALU_ARITH_FLAG, ALU_LOGIC_FLAG, ALU_CMP_FLAG, ALU_SHIFT_FLAG};
        res_err_s   = (res_flags_s != class_flags(cls_r));
    end

    // Next-state logic; divide-by-zero skips the ALU entirely.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (gnt_vld_s) begin
                    state_s = div0_s ? ST_RESP : ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 3'd0) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (RSP_READY) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_RESP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State, priority, owner, class and latency counter registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= ST_IDLE;
            prio_r  <= 1'b0;
            id_r    <= 1'b0;
            cnt_r   <= 3'd0;
            cls_r   <= 2'b00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s != ST_IDLE);
            if (state_r == ST_IDLE && gnt_vld_s) begin
                prio_r <= ~gnt_id_s;
                id_r   <= gnt_id_s;
                cnt_r  <= LAT_C;
                cls_r  <= sel_fun_s[3:2];
            end else if (state_r == ST_WAIT && cnt_r != 3'd0) begin
                cnt_r <= cnt_r - 3'd1;
            end
        end
    end

    // ALU operand registers: loaded on a real grant, otherwise held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            alu_a_r   <= {DATA_WIDTH{1'b0}};
            alu_b_r   <= {DATA_WIDTH{1'b0}};
            alu_fun_r <= 4'b0000;
        end else if (state_r == ST_IDLE && gnt_vld_s && !div0_s) begin
            alu_a_r   <= sel_a_s;
            alu_b_r   <= sel_b_s;
            alu_fun_r <= sel_fun_s;
        end
    end

    // Response registers: filled on capture or divide-by-zero, held until consumed.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= 1'b0;
            rsp_data_r  <= {DATA_WIDTH{1'b0}};
            rsp_carry_r <= 1'b0;
            rsp_flags_r <= 4'b0000;
            rsp_err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (gnt_vld_s && div0_s) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= gnt_id_s;
                        rsp_data_r  <= {DATA_WIDTH{1'b1}};
                        rsp_carry_r <= 1'b0;
                        rsp_flags_r <= 4'b0000;
                        rsp_err_r   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 3'd0) begin
                        rsp_valid_r <= 1'b1;
                        rsp_id_r    <= id_r;
                        rsp_data_r  <= res_data_s;
                        rsp_carry_r <= res_carry_s;
                        rsp_flags_r <= res_flags_s;
                        rsp_err_r   <= res_err_s;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_r <= 1'b0;
                    end
                end
                default: rsp_valid_r <= 1'b0;
            endcase
        end
    end

    assign RSP_VALID = rsp_valid_r;
    assign RSP_ID    = rsp_id_r;
    assign RSP_DATA  = rsp_data_r;
    assign RSP_CARRY = rsp_carry_r;
    assign RSP_FLAGS = rsp_flags_r;
    assign RSP_ERR   = rsp_err_r;
    assign BUSY      = busy_r;
    assign ALU_A     = alu_a_r;
    assign ALU_B     = alu_b_r;
    assign ALU_FUN   = alu_fun_r;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Self-checking bench for alu_rr_scheduler with a behavioural ALU_TOP model
// (one register stage) and a response scoreboard.
`timescale 1ns/1ps
module tb_alu_rr_scheduler;

    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          REQ0_VALID = 1'b0, REQ1_VALID = 1'b0;
    logic          REQ0_READY, REQ1_READY;
    logic [DW-1:0] REQ0_A = 16'd0, REQ0_B = 16'd0, REQ1_A = 16'd0, REQ1_B = 16'd0;
    logic [3:0]    REQ0_FUN = 4'd0, REQ1_FUN = 4'd0;
    logic          RSP_VALID, RSP_READY = 1'b1, RSP_ID, RSP_CARRY, RSP_ERR, BUSY;
    logic [DW-1:0] RSP_DATA, ALU_A, ALU_B;
    logic [3:0]    RSP_FLAGS, ALU_FUN;
    logic [DW-1:0] ALU_ARITH_OUT = 16'd0, ALU_LOGIC_OUT = 16'd0;
    logic [DW-1:0] ALU_CMP_OUT = 16'd0, ALU_SHIFT_OUT = 16'd0;
    logic          ALU_CARRY_OUT = 1'b0;
    logic          ALU_ARITH_FLAG = 1'b0, ALU_LOGIC_FLAG = 1'b0;
    logic          ALU_CMP_FLAG = 1'b0, ALU_SHIFT_FLAG = 1'b0;
    logic [3:0]    flag_xor = 4'b0000;

    alu_rr_scheduler #(.DATA_WIDTH(DW), .ALU_LATENCY(1)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0_VALID(REQ0_VALID), .REQ0_READY(REQ0_READY), .REQ0_A(REQ0_A), .REQ0_B(REQ0_B), .REQ0_FUN(REQ0_FUN),
        .REQ1_VALID(REQ1_VALID), .REQ1_READY(REQ1_READY), .REQ1_A(REQ1_A), .REQ1_B(REQ1_B), .REQ1_FUN(REQ1_FUN),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA),
        .RSP_CARRY(RSP_CARRY), .RSP_FLAGS(RSP_FLAGS), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN),
        .ALU_ARITH_OUT(ALU_ARITH_OUT), .ALU_LOGIC_OUT(ALU_LOGIC_OUT),
        .ALU_CMP_OUT(ALU_CMP_OUT), .ALU_SHIFT_OUT(ALU_SHIFT_OUT), .ALU_CARRY_OUT(ALU_CARRY_OUT),
        .ALU_ARITH_FLAG(ALU_ARITH_FLAG), .ALU_LOGIC_FLAG(ALU_LOGIC_FLAG),
        .ALU_CMP_FLAG(ALU_CMP_FLAG), .ALU_SHIFT_FLAG(ALU_SHIFT_FLAG)
    );

    always #5 CLK = ~CLK;

    // ---------------- ALU_TOP model (all units evaluated every cycle) ----------------
    function automatic logic [16:0] m_arith(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return {1'b0, a} + {1'b0, b};
            2'b01:   return {1'b0, a} - {1'b0, b};
            2'b10:   return {1'b0, 16'(a * b)};
            default: return (b == 16'd0) ? 17'd0 : {1'b0, a / b};
        endcase
    endfunction
    function automatic logic [15:0] m_logic(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return ~(a & b);
            default: return ~(a | b);
        endcase
    endfunction
    function automatic logic [15:0] m_cmp(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return 16'd0;
            2'b01:   return (a == b) ? 16'd1 : 16'd0;
            2'b10:   return (a > b)  ? 16'd2 : 16'd0;
            default: return (a < b)  ? 16'd3 : 16'd0;
        endcase
    endfunction
    function automatic logic [15:0] m_shift(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'b00:   return a >> 1;
            2'b01:   return a << 1;
            2'b10:   return b >> 1;
            default: return b << 1;
        endcase
    endfunction

    always @(posedge CLK) begin
        {ALU_CARRY_OUT, ALU_ARITH_OUT} <= m_arith(ALU_FUN[1:0], ALU_A, ALU_B);
        ALU_LOGIC_OUT <= m_logic(ALU_FUN[1:0], ALU_A, ALU_B);
        ALU_CMP_OUT   <= m_cmp(ALU_FUN[1:0], ALU_A, ALU_B);
        ALU_SHIFT_OUT <= m_shift(ALU_FUN[1:0], ALU_A, ALU_B);
        {ALU_ARITH_FLAG, ALU_LOGIC_FLAG, ALU_CMP_FLAG, ALU_SHIFT_FLAG} <= (4'b1000 >> ALU_FUN[3:2]) ^ flag_xor;
    end

    // ---------------- bookkeeping ----------------
    typedef struct packed {
        logic        id;
        logic [15:0] data;
        logic        carry;
        logic [3:0]  flags;
        logic        err;
    } rsp_t;

    typedef struct {
        rsp_t r;
        int   lat;
        int   acc;
    } sb_t;

    typedef struct {
        logic        id;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic [3:0]  fx;
        logic [15:0] d;
        logic        c;
        logic [3:0]  f;
        logic        e;
        int          lat;
    } vec_t;

    sb_t         sb[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        seen    = 1'b0;
    logic [15:0] last_a  = 16'd0, last_b = 16'd0;
    logic [3:0]  last_fun = 4'd0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rsp_t mk(input logic id, input logic [15:0] d, input logic c, input logic [3:0] f, input logic e);
        rsp_t r;
        r.id = id; r.data = d; r.carry = c; r.flags = f; r.err = e;
        return r;
    endfunction

    // Response monitor: latency on rise, full contents on handshake.
    always @(negedge CLK) begin
        if (RST) begin
            seen = 1'b0;
        end else begin
            if (RSP_VALID && !seen) begin
                seen = 1'b1;
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 64'(RSP_VALID), 64'(0));
                end else begin
                    chk("rsp_latency", 64'(cyc - sb[0].acc), 64'(sb[0].lat));
                end
            end
            if (RSP_VALID && RSP_READY) begin
                seen = 1'b0;
                if (sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("rsp_contents", 64'({RSP_ID, RSP_DATA, RSP_CARRY, RSP_FLAGS, RSP_ERR}), 64'(e.r));
                end
            end
        end
    end

    task automatic drive(input logic id, input logic [15:0] a, input logic [15:0] b, input logic [3:0] fun);
        if (id) begin
            REQ1_VALID = 1'b1; REQ1_A = a; REQ1_B = b; REQ1_FUN = fun;
        end else begin
            REQ0_VALID = 1'b1; REQ0_A = a; REQ0_B = b; REQ0_FUN = fun;
        end
    endtask

    // Wait for this requester's grant, push its expectation, check ALU operands.
    task automatic wait_accept(input logic id, input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] fun, input rsp_t exp, input int lat, output int waited);
        logic got, bad;
        sb_t  e;
        got = 1'b0; bad = 1'b0; waited = 0;
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge CLK);
            if ((id ? REQ1_READY : REQ0_READY) === 1'b1) begin
                got = 1'b1;
            end else begin
                waited++;
                if ((id ? REQ0_READY : REQ1_READY) === 1'b1) bad = 1'b1;
            end
        end
        chk("grant_order", 64'(bad), 64'(0));
        chk("accept_timeout", 64'(got), 64'(1));
        if (got) begin
            e.r = exp; e.lat = lat; e.acc = cyc + 1;
            sb.push_back(e);
            @(posedge CLK); #1;
            if (id) REQ1_VALID = 1'b0; else REQ0_VALID = 1'b0;
            if (!(fun == 4'b0011 && b == 16'd0)) begin
                last_a = a; last_b = b; last_fun = fun;
            end
            @(negedge CLK);
            chk("alu_inputs", 64'({ALU_A, ALU_B, ALU_FUN}), 64'({last_a, last_b, last_fun}));
        end else begin
            if (id) REQ1_VALID = 1'b0; else REQ0_VALID = 1'b0;
        end
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 60 && !done; k++) begin
            @(negedge CLK);
            if (sb.size() == 0 && !RSP_VALID) done = 1'b1;
        end
        chk("drain_timeout", 64'(done), 64'(1));
    endtask

    task automatic reset_dut();
        @(posedge CLK); #1;
        RST = 1'b1;
        sb.delete();
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        chk(name, 64'({RSP_VALID, RSP_ID, RSP_DATA, RSP_CARRY, RSP_FLAGS, RSP_ERR, BUSY, ALU_A, ALU_B, ALU_FUN}), 64'(0));
    endtask

    vec_t vecs[12];
    int   w;

    initial begin
        vecs[0]  = '{1'b0, 16'd217,   16'd109,   4'b0000, 4'b0000, 16'd326,   1'b0, 4'b1000, 1'b0, 2};
        vecs[1]  = '{1'b1, 16'h8FFF,  16'h8FBA,  4'b0000, 4'b0000, 16'h1FB9,  1'b1, 4'b1000, 1'b0, 2};
        vecs[2]  = '{1'b0, 16'h0010,  16'h0003,  4'b0001, 4'b0000, 16'h000D,  1'b0, 4'b1000, 1'b0, 2};
        vecs[3]  = '{1'b1, 16'h00F0,  16'h0F00,  4'b0101, 4'b0000, 16'h0FF0,  1'b0, 4'b0100, 1'b0, 2};
        vecs[4]  = '{1'b0, 16'd36,    16'd0,     4'b0011, 4'b0000, 16'hFFFF,  1'b0, 4'b0000, 1'b1, 0};
        vecs[5]  = '{1'b1, 16'd36,    16'd6,     4'b0011, 4'b0000, 16'd6,     1'b0, 4'b1000, 1'b0, 2};
        vecs[6]  = '{1'b0, 16'd3,     16'd9,     4'b1011, 4'b0000, 16'd3,     1'b0, 4'b0010, 1'b0, 2};
        vecs[7]  = '{1'b1, 16'h0001,  16'h0100,  4'b1110, 4'b0000, 16'h0080,  1'b0, 4'b0001, 1'b0, 2};
        vecs[8]  = '{1'b0, 16'hFF00,  16'h0FF0,  4'b0100, 4'b0001, 16'h0F00,  1'b0, 4'b0101, 1'b1, 2};
        vecs[9]  = '{1'b1, 16'd300,   16'd3,     4'b0010, 4'b0000, 16'd900,   1'b0, 4'b1000, 1'b0, 2};
        vecs[10] = '{1'b0, 16'h0000,  16'h0000,  4'b0111, 4'b0000, 16'hFFFF,  1'b0, 4'b0100, 1'b0, 2};
        vecs[11] = '{1'b1, 16'd2,     16'd5,     4'b1010, 4'b0000, 16'd0,     1'b0, 4'b0010, 1'b0, 2};

        // Reset state
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check_all_zero("reset_outputs");

        // Single-requester vectors
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK); #1;
            flag_xor = vecs[i].fx;
            drive(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].fun);
            wait_accept(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].fun,
                        mk(vecs[i].id, vecs[i].d, vecs[i].c, vecs[i].f, vecs[i].e), vecs[i].lat, w);
            chk("ready_same_cycle", 64'(w), 64'(0));
            drain();
            flag_xor = 4'b0000;
        end

        // Contention from reset: REQ0, REQ1, then REQ0 again
        reset_dut();
        drive(1'b0, 16'h00B6, 16'h006C, 4'b0100);
        drive(1'b1, 16'd5, 16'd2, 4'b1010);
        wait_accept(1'b0, 16'h00B6, 16'h006C, 4'b0100, mk(1'b0, 16'h0024, 1'b0, 4'b0100, 1'b0), 2, w);
        chk("contend_first_immediate", 64'(w), 64'(0));
        wait_accept(1'b1, 16'd5, 16'd2, 4'b1010, mk(1'b1, 16'd2, 1'b0, 4'b0010, 1'b0), 2, w);
        @(posedge CLK); #1;
        drive(1'b0, 16'd1, 16'd1, 4'b0000);
        drive(1'b1, 16'd3, 16'd4, 4'b0000);
        wait_accept(1'b0, 16'd1, 16'd1, 4'b0000, mk(1'b0, 16'd2, 1'b0, 4'b1000, 1'b0), 2, w);
        wait_accept(1'b1, 16'd3, 16'd4, 4'b0000, mk(1'b1, 16'd7, 1'b0, 4'b1000, 1'b0), 2, w);
        drain();

        // Back-pressure during a shift-left, with both requesters waiting
        @(posedge CLK); #1;
        RSP_READY = 1'b0;
        drive(1'b0, 16'h0032, 16'h0000, 4'b1101);
        wait_accept(1'b0, 16'h0032, 16'h0000, 4'b1101, mk(1'b0, 16'h0064, 1'b0, 4'b0001, 1'b0), 2, w);
        @(posedge CLK); #1;
        drive(1'b0, 16'h1234, 16'h0001, 4'b0101);
        drive(1'b1, 16'h00F0, 16'h003C, 4'b0100);
        begin
            logic vis;
            vis = 1'b0;
            for (int k = 0; k < 20 && !vis; k++) begin
                @(negedge CLK);
                if (RSP_VALID) vis = 1'b1;
            end
            chk("bp_rsp_timeout", 64'(vis), 64'(1));
        end
        for (int k = 0; k < 5; k++) begin
            if (k != 0) @(negedge CLK);
            chk("bp_hold", 64'({RSP_VALID, RSP_DATA, REQ0_READY, REQ1_READY, BUSY}),
                64'({1'b1, 16'h0064, 1'b0, 1'b0, 1'b1}));
        end
        @(posedge CLK); #1;
        RSP_READY = 1'b1;
        wait_accept(1'b1, 16'h00F0, 16'h003C, 4'b0100, mk(1'b1, 16'h0030, 1'b0, 4'b0100, 1'b0), 2, w);
        chk("grant_after_handshake", 64'(w), 64'(1));
        wait_accept(1'b0, 16'h1234, 16'h0001, 4'b0101, mk(1'b0, 16'h1235, 1'b0, 4'b0100, 1'b0), 2, w);
        drain();

        // Reset in WAIT drops the op and restarts priority at requester 0
        @(posedge CLK); #1;
        drive(1'b0, 16'd7, 16'd8, 4'b0000);
        wait_accept(1'b0, 16'd7, 16'd8, 4'b0000, mk(1'b0, 16'd15, 1'b0, 4'b1000, 1'b0), 2, w);
        @(posedge CLK); #1;
        chk("in_wait_busy", 64'(BUSY), 64'(1));
        RST = 1'b1;
        sb.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check_all_zero("midwait_reset_outputs");
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("no_rsp_after_reset", 64'(RSP_VALID), 64'(0));
        end
        @(posedge CLK); #1;
        drive(1'b0, 16'd9, 16'd4, 4'b0001);
        drive(1'b1, 16'd4, 16'd4, 4'b1001);
        wait_accept(1'b0, 16'd9, 16'd4, 4'b0001, mk(1'b0, 16'd5, 1'b0, 4'b1000, 1'b0), 2, w);
        wait_accept(1'b1, 16'd4, 16'd4, 4'b1001, mk(1'b1, 16'd1, 1'b0, 4'b0010, 1'b0), 2, w);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
